// File: rtl/l_class_fifo1_arb2.sv
// l_class_fifo1_arb2: two-producer round-robin arbiter owning a one-entry FIFO, source-tagged entries, per-source grant counters.
// Latency: an accepted element is visible on out_first one cycle after acceptance (no enq_v -> first bypass).
// Backpressure: both enq RDY are low while the entry is full; under contention only the priority port is ready.
module l_class_fifo1_arb2 #(
    parameter int WIDTH = 704,
    parameter int CNTW  = 16
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             in0_enq__ENA,
    input  logic [WIDTH-1:0] in0_enq_v,
    output logic             in0_enq__RDY,
    input  logic             in1_enq__ENA,
    input  logic [WIDTH-1:0] in1_enq_v,
    output logic             in1_enq__RDY,
    output logic [WIDTH-1:0] out_first,
    output logic             out_first_src,
    output logic             out_first__RDY,
    input  logic             out_deq__ENA,
    output logic             out_deq__RDY,
    output logic [CNTW-1:0]  grant_cnt0,
    output logic [CNTW-1:0]  grant_cnt1
);

    // Held entry, its source tag, occupancy, round-robin pointer and grant counters.
    logic [WIDTH-1:0] element_q, element_d;
    logic             src_q, src_d;
    logic             full_q, full_d;
    logic             prio_q, prio_d;
    logic [CNTW-1:0]  cnt0_q, cnt0_d;
    logic [CNTW-1:0]  cnt1_q, cnt1_d;

    // Method-level ready and effective-enable terms.
    logic rdy0, rdy1, acc0, acc1, acc_deq;

    // A port loses readiness only when the other port is requesting and holds priority.
    // Ready never looks at enq_v, so there is no data -> ready path.
    always_comb begin
        rdy0    = !full_q && !(in1_enq__ENA && prio_q);
        rdy1    = !full_q && !(in0_enq__ENA && !prio_q);
        acc0    = in0_enq__ENA && rdy0;
        acc1    = in1_enq__ENA && rdy1;
        acc_deq = out_deq__ENA && full_q;
    end

    // Next state: an accepted enqueue loads the entry and hands priority to the other port;
    // a dequeue only clears occupancy, leaving the stale element and tag in place.
    always_comb begin
        element_d = element_q;
        src_d     = src_q;
        full_d    = full_q;
        prio_d    = prio_q;
        cnt0_d    = cnt0_q;
        cnt1_d    = cnt1_q;
        if (acc0) begin
            element_d = in0_enq_v;
            src_d     = 1'b0;
            full_d    = 1'b1;
            prio_d    = 1'b1;
            cnt0_d    = cnt0_q + 1'b1;
        end else if (acc1) begin
            element_d = in1_enq_v;
            src_d     = 1'b1;
            full_d    = 1'b1;
            prio_d    = 1'b0;
            cnt1_d    = cnt1_q + 1'b1;
        end
        // Enqueue needs !full and dequeue needs full, so the two never collide here.
        if (acc_deq) begin
            full_d = 1'b0;
        end
    end

    // State register; reset wins over any enable in the same cycle and drops the held entry.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            element_q <= '0;
            src_q     <= 1'b0;
            full_q    <= 1'b0;
            prio_q    <= 1'b0;
            cnt0_q    <= '0;
            cnt1_q    <= '0;
        end else begin
            element_q <= element_d;
            src_q     <= src_d;
            full_q    <= full_d;
            prio_q    <= prio_d;
            cnt0_q    <= cnt0_d;
            cnt1_q    <= cnt1_d;
        end
    end

    assign in0_enq__RDY   = rdy0;
    assign in1_enq__RDY   = rdy1;
    assign out_first      = element_q;
    assign out_first_src  = src_q;
    assign out_first__RDY = full_q;
    assign out_deq__RDY   = full_q;
    assign grant_cnt0     = cnt0_q;
    assign grant_cnt1     = cnt1_q;

endmodule

// File: tb/tb_l_class_fifo1_arb2.sv
// Bench for l_class_fifo1_arb2: directed steps, scoreboard of enqueued entries popped on dequeue.
// Counters are narrowed to 8 bits so wrap-around is reachable in a short run.
// Inputs change 1 time unit after the rising edge; outputs are sampled before the next edge.
module tb_l_class_fifo1_arb2;
    localparam int WIDTH = 704;
    localparam int CNTW  = 8;

    logic             clk = 1'b0;
    logic             nrst, e0, e1, deq;
    logic [WIDTH-1:0] v0, v1;
    logic             rdy0, rdy1, fsrc, frdy, drdy;
    logic [WIDTH-1:0] first;
    logic [CNTW-1:0]  cnt0, cnt1;

    always #5 clk = ~clk;

    l_class_fifo1_arb2 #(.WIDTH(WIDTH), .CNTW(CNTW)) dut (
        .CLK(clk),
        .nRST(nrst),
        .in0_enq__ENA(e0),
        .in0_enq_v(v0),
        .in0_enq__RDY(rdy0),
        .in1_enq__ENA(e1),
        .in1_enq_v(v1),
        .in1_enq__RDY(rdy1),
        .out_first(first),
        .out_first_src(fsrc),
        .out_first__RDY(frdy),
        .out_deq__ENA(deq),
        .out_deq__RDY(drdy),
        .grant_cnt0(cnt0),
        .grant_cnt1(cnt1)
    );

    // Reference state
    logic             mfull, mprio, msrc;
    logic [WIDTH-1:0] melem;
    logic [CNTW-1:0]  mcnt0, mcnt1;
    logic [WIDTH:0]   sb[$];
    logic [WIDTH-1:0] popped[$];
    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: check ready/accept against the reference before the edge, then state after it.
    task automatic cycle();
        logic r0, r1, a0, a1, ad;
        logic [WIDTH:0] h;
        #1;
        r0 = !mfull && !(e1 && mprio);
        r1 = !mfull && !(e0 && !mprio);
        chk("in0_rdy", rdy0, r0);
        chk("in1_rdy", rdy1, r1);
        a0 = e0 && r0;
        a1 = e1 && r1;
        ad = deq && mfull;
        if (nrst && ad) begin
            checks++;
            assert (sb.size() != 0) else begin
                errors++;
                $error("FAIL sb_underflow observed=dequeue expected=no_dequeue");
            end
            if (sb.size() != 0) begin
                h = sb.pop_front();
                chk("deq_data", first, h[WIDTH-1:0]);
                chk("deq_src", fsrc, h[WIDTH]);
                popped.push_back(first);
            end
        end
        @(posedge clk);
        if (!nrst) begin
            mfull = 1'b0; mprio = 1'b0; msrc = 1'b0; melem = '0;
            mcnt0 = '0; mcnt1 = '0;
            sb.delete();
        end else begin
            if (a0) begin
                sb.push_back({1'b0, v0});
                melem = v0; msrc = 1'b0; mfull = 1'b1; mprio = 1'b1; mcnt0 = mcnt0 + 1'b1;
            end else if (a1) begin
                sb.push_back({1'b1, v1});
                melem = v1; msrc = 1'b1; mfull = 1'b1; mprio = 1'b0; mcnt1 = mcnt1 + 1'b1;
            end
            if (ad) mfull = 1'b0;
        end
        #1;
        chk("first", first, melem);
        chk("first_src", fsrc, msrc);
        chk("first_rdy", frdy, mfull);
        chk("deq_rdy", drdy, mfull);
        chk("cnt0", cnt0, mcnt0);
        chk("cnt1", cnt1, mcnt1);
    endtask

    initial begin
        logic [WIDTH-1:0] exp_order [4];
        exp_order[0] = 'h11; exp_order[1] = 'h22; exp_order[2] = 'h11; exp_order[3] = 'h22;
        mfull = 1'b0; mprio = 1'b0; msrc = 1'b0; melem = '0; mcnt0 = '0; mcnt1 = '0;
        nrst = 1'b0; e0 = 1'b0; e1 = 1'b0; deq = 1'b0; v0 = '0; v1 = '0;

        // Reset held two cycles, then idle
        cycle(); cycle();
        nrst = 1'b1;
        cycle();
        chk("rst_rdy0", rdy0, 1'b1);
        chk("rst_rdy1", rdy1, 1'b1);
        chk("rst_first_rdy", frdy, 1'b0);
        chk("rst_first", first, '0);
        chk("rst_cnt0", cnt0, '0);

        // Lone enqueue on in0
        e0 = 1'b1; v0 = 'h5A;
        cycle();
        e0 = 1'b0;
        chk("lone_first", first, 'h5A);
        chk("lone_cnt0", cnt0, 1);
        chk("lone_rdy0_full", rdy0, 1'b0);
        chk("lone_rdy1_full", rdy1, 1'b0);
        cycle();
        deq = 1'b1;
        cycle();
        deq = 1'b0;
        cycle();
        chk("lone_rdy0_after_deq", rdy0, 1'b1);
        chk("lone_rdy1_after_deq", rdy1, 1'b1);

        // Cross-gating with prio=1, empty
        e1 = 1'b1;
        #1;
        chk("cross_rdy0_blocked", rdy0, 1'b0);
        chk("cross_rdy1", rdy1, 1'b1);
        e1 = 1'b0;
        #1;
        chk("cross_rdy0_released", rdy0, 1'b1);

        // Enqueue ignored while full
        e0 = 1'b1; v0 = 'h42;
        cycle();
        v0 = 'h99;
        cycle(); cycle();
        e0 = 1'b0;
        chk("full_hold_first", first, 'h42);
        chk("full_hold_cnt0", cnt0, 2);
        deq = 1'b1;
        cycle();
        deq = 1'b0;

        // Contention fairness from a fresh reset
        nrst = 1'b0;
        cycle();
        nrst = 1'b1;
        popped.delete();
        e0 = 1'b1; e1 = 1'b1; v0 = 'h11; v1 = 'h22; deq = 1'b1;
        repeat (8) cycle();
        e0 = 1'b0; e1 = 1'b0; deq = 1'b0;
        checks++;
        assert (popped.size() == 4) else begin
            errors++;
            $error("FAIL fair_count observed=%0d expected=4", popped.size());
        end
        for (int i = 0; i < 4; i++) begin
            if (i < popped.size()) chk("fair_order", popped[i], exp_order[i]);
        end
        chk("fair_cnt0", cnt0, 2);
        chk("fair_cnt1", cnt1, 2);

        // Counter wrap on in1
        nrst = 1'b0;
        cycle();
        nrst = 1'b1;
        v1 = 'h7;
        for (int i = 0; i < (1 << CNTW) - 1; i++) begin
            e1 = 1'b1; deq = 1'b0;
            cycle();
            e1 = 1'b0; deq = 1'b1;
            cycle();
        end
        deq = 1'b0;
        chk("wrap_cnt1_max", cnt1, (1 << CNTW) - 1);
        e1 = 1'b1; v1 = 'h3C;
        cycle();
        e1 = 1'b0;
        chk("wrap_cnt1_zero", cnt1, 0);
        chk("wrap_full", frdy, 1'b1);

        // Reset while full, with deq and both enqueues asserted
        nrst = 1'b0; deq = 1'b1; e0 = 1'b1; e1 = 1'b1; v0 = 'hAB; v1 = 'hCD;
        cycle();
        nrst = 1'b1; deq = 1'b0; e0 = 1'b0; e1 = 1'b0;
        chk("mrst_full", frdy, 1'b0);
        chk("mrst_first", first, '0);
        chk("mrst_cnt0", cnt0, 0);
        chk("mrst_cnt1", cnt1, 0);
        e0 = 1'b1; e1 = 1'b1;
        #1;
        chk("mrst_prio_rdy0", rdy0, 1'b1);
        chk("mrst_prio_rdy1", rdy1, 1'b0);
        e0 = 1'b0; e1 = 1'b0;
        cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/l_class_fifo1_arb2.md
Name: l_class_fifo1_arb2

Overview:
- Two-requester round-robin arbiter that owns a one-entry FIFO (element register plus full flag) and shares its enqueue side between two producers, in0 and in1.
- A single consumer drains the buffer through the usual first/deq interface.
- Each enqueued element is tagged with its source. Per-source grant counters are kept for observability.
- Sits between two producer rule-sets and one consumer in the generated datapath, replacing ad-hoc muxing in front of single-entry FIFOs.

Parameters:
WIDTH, 704, data width of the element and of each enq_v.
CNTW, 16, width of each per-source grant counter.

Ports:
CLK  input  1  clock, all state updates on posedge
nRST  input  1  synchronous active-low reset, sampled on posedge CLK
in0$enq__ENA  input  1  producer 0 enqueue request
in0$enq_v  input  WIDTH  producer 0 data
in0$enq__RDY  output  1  producer 0 may enqueue this cycle
in1$enq__ENA  input  1  producer 1 enqueue request
in1$enq_v  input  WIDTH  producer 1 data
in1$enq__RDY  output  1  producer 1 may enqueue this cycle
out$first  output  WIDTH  head element
out$first_src  output  1  source of head element (0 = in0, 1 = in1)
out$first__RDY  output  1  head valid
out$deq__ENA  input  1  consumer dequeue
out$deq__RDY  output  1  dequeue allowed
grant_cnt0  output  CNTW  number of enqueues accepted from in0
grant_cnt1  output  CNTW  number of enqueues accepted from in1

Behaviour:
- State: element[WIDTH], src, full, prio, grant_cnt0, grant_cnt1.
- prio = 0 means in0 wins a tie; prio = 1 means in1 wins a tie.
- Reset (nRST=0 at posedge): element=0, src=0, full=0, prio=0, both counters=0. Reset overrides any ENA in the same cycle. Mid-operation reset discards the held element and does not count as a dequeue.
- Reset-visible outputs: out$first=0, out$first_src=0, out$first__RDY=0, out$deq__RDY=0, in0$enq__RDY=1, in1$enq__RDY=1.
- out$first=element, out$first_src=src, out$first__RDY=full, out$deq__RDY=full.
- Ready equations:
  - in0$enq__RDY = !full && !(in1$enq__ENA && prio==1)
  - in1$enq__RDY = !full && !(in0$enq__ENA && prio==0)
  - At most one enqueue is accepted per cycle.
- Effective enable: ENA_internal = ENA && RDY on every method. ENA while RDY=0 is ignored with no state change.
- Accepted enqueue from inN: next cycle element=inN$enq_v, src=N, full=1, prio=!N, grant_cntN+1.
  - Latency: data is visible on out$first one cycle after acceptance.
  - No bypass from enq_v to out$first.
- prio changes only on an accepted enqueue. A lone requester is served regardless of prio, and prio still flips to the other port.
- Accepted deq: full=0 next cycle. element and src hold their values (stale, not cleared).
- Simultaneous deq and enq cannot occur: enq RDY requires !full and deq RDY requires full. Throughput is at most one element per two cycles, matching the single-entry FIFO.
- Counters wrap modulo 2^CNTW, with no saturation (0xFFFF+1 -> 0 at CNTW=16).
- No combinational path from in*$enq_v to any RDY. in0 RDY depends combinationally on in1 ENA, and vice versa, which is a legal ENA->RDY cross path.

Test Plan:
- Reset then idle: hold nRST=0 two cycles, release -> both enq RDY=1, out$first__RDY=0, counters 0, out$first=0.
- Lone enqueue: in0 ENA with v=0x5A, then nothing -> next cycle full=1, out$first=0x5A, src=0, grant_cnt0=1, prio=1. Both enq RDY=0 until deq. Deq -> both enq RDY=1 the following cycle.
- Contention fairness: both ENA held high with v0=0x11, v1=0x22, deq asserted whenever RDY -> accepted order 0x11, 0x22, 0x11, 0x22. After 4 grants, cnt0=2 and cnt1=2.
- RDY cross-gating: prio=1, in1 ENA=1, full=0 -> in0$enq__RDY=0, in1$enq__RDY=1. Drop in1 ENA -> in0$enq__RDY=1 in the same cycle.
- Enqueue ignored when full: full=1, in0 ENA with 0x99 -> element unchanged, cnt0 unchanged.
- Reset mid-operation plus counter wrap:
  - Force cnt1=0xFFFF via 65535 grants, then one more in1 grant -> cnt1=0.
  - With full=1, assert nRST=0 together with deq and enq -> full=0, prio=0, counters 0; no enqueue accepted.
